twiddle_fetch: RTL and testbench
================================

Name: twiddle_fetch

Overview:
- Initiator side of the twiddle ROM index interface: sweeps (k, n) over an N-point DFT grid and drives N/k_index/n_index to the ROM.
- Absorbs the ROM's fixed 1-cycle registered read latency.
- Delivers twiddle words, tagged with their indices, on a valid/ready stream to the butterfly datapath.
- Sits between the FFT control sequencer (start/done) and the ROM.

Parameters:
- WIDTH, 32, twiddle word width; [WIDTH-1:WIDTH/2] = re, [WIDTH/2-1:0] = im, both 2's complement.
- IDX_W, 12, width of N, k and n indices.
- FIFO_DEPTH, 4, output buffer entries; must be >= 3 for full throughput.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin a sweep; sampled only in IDLE
- n_len  in  IDX_W  transform length N; legal values are powers of two, 2..2048
- busy  out  1  high in RUN or DRAIN
- done  out  1  one-cycle pulse at sweep completion
- err  out  1  one-cycle pulse when start arrives with an illegal n_len
- rom_N  out  IDX_W  to ROM N; holds the latched n_len
- rom_k  out  IDX_W  to ROM k_index; registered
- rom_n  out  IDX_W  to ROM n_index; registered
- rom_data  in  WIDTH  ROM data; valid one clk edge after rom_k/rom_n are presented
- tw_data  out  WIDTH  twiddle word
- tw_k  out  IDX_W  k tag of tw_data
- tw_n  out  IDX_W  n tag of tw_data
- tw_last  out  1  marks the final word (k = n = N-1)
- tw_valid  out  1  stream valid
- tw_ready  in  1  stream ready

Behaviour:
- Reset (async assert, sync release): state IDLE. All outputs 0. FIFO emptied; in-flight count 0; rom_N/rom_k/rom_n 0.
- State machine:
  - IDLE: on start with legal n_len, latch N, set k = n = 0, go to RUN. On start with illegal n_len (0, 1, non-power-of-two, 4096 wraps to 0), pulse err the next cycle and stay in IDLE.
  - RUN: issue one index per cycle while (FIFO occupancy + in-flight) < FIFO_DEPTH. Issue order: n inner 0..N-1, k outer 0..N-1. Issuing (N-1, N-1) moves the FSM to DRAIN.
  - DRAIN: no issues. When in-flight = 0 and the FIFO is empty, pulse done and go to IDLE.
- Pipeline: an index is registered at edge E0 and the ROM samples it at E1. rom_data is written to the FIFO with its k/n/last tags at E2. tw_valid can first rise after E2.
- In-flight counter tracks this 2-stage pipe: incremented on issue, decremented on FIFO write. It never exceeds 2.
- Credit rule guarantees no FIFO overflow. FIFO writes are never dropped.
- rom_k/rom_n hold their last issued value when not issuing; extra ROM reads are harmless and are not captured.
- Stream: tw_data/tw_k/tw_n/tw_last stay stable while tw_valid=1 and tw_ready=0. A transfer happens when both are high. Simultaneous FIFO write and read are supported at full occupancy.
- With tw_ready held high, throughput is 1 word/clk after the initial 2-cycle latency. Total words per sweep = N*N.
- Address arithmetic is done by the ROM: (4096/N)*k*n mod 2^IDX_W. This block performs no address math.
- start while busy is ignored; no err pulse.
- done is asserted only after the tw_last handshake, at the earliest one cycle after it.
- Reset mid-sweep: immediate abort to IDLE with the FIFO flushed; no done pulse.

Optional Feature:
- Macro TWIDDLE_FETCH_CONJ_EN.
- Defined: adds input port inv (1 bit), latched at start. When latched inv=1, the im half of each word is negated at FIFO output. -32768 saturates to +32767. The re half is unchanged. This serves the inverse FFT.
- Undefined: the inv port is absent and words pass through unmodified.

Decomposition:
- Package twiddle_pkg:
  - constants TW_WIDTH=32, TW_IDX_W=12, TW_ROM_DEPTH=4096
  - typedef tw_word_t (packed struct re/im, 16 bits each)
  - typedef tw_tag_t (k, n, last)
  - enum fetch_state_t {IDLE, RUN, DRAIN}
- Sub-module twiddle_skid_fifo: synchronous FIFO of FIFO_DEPTH entries with valid/ready read side, carrying {tw_word_t, tw_tag_t}, exposing an occupancy count.

Test Plan:
- N=2, tw_ready=1: expect 4 words with (k,n) = (0,0),(0,1),(1,0),(1,1). Data = rom[0],rom[0],rom[0],rom[2048]. tw_last only on the 4th. done 1 cycle later. First tw_valid 2 edges after the start edge.
- N=8, tw_ready toggled by a random 50% pattern: expect 64 words in order, each data = rom[(512*k*n)%4096], no loss or duplication, and the FIFO never exceeds 4.
- tw_ready held 0 for 20 cycles mid-sweep (N=16): expect issue to stall after 4 outstanding entries, tw_data stable throughout, correct resume.
- start with n_len = 0, 3, 12: expect an err pulse each time, busy stays 0, no ROM index change. start during RUN is ignored.
- rst_n asserted at word 30 of an N=8 sweep: expect all outputs 0 immediately and no done pulse. A subsequent N=4 sweep completes cleanly with 16 words.
- TWIDDLE_FETCH_CONJ_EN with inv=1, ROM word re=0x5A82 im=0xA57E: expect output im=0x5A82. Case im=0x8000: expect output im=0x7FFF.

Source files
------------

// File: rtl/twiddle_pkg.sv
// Shared types and constants for the twiddle index fetcher and its output buffer.
package twiddle_pkg;

   localparam int TW_WIDTH     = 32;
   localparam int TW_IDX_W     = 12;
   localparam int TW_ROM_DEPTH = 4096;
   localparam int TW_HALF      = TW_WIDTH / 2;

   typedef struct packed {
      logic [TW_HALF-1:0] re;
      logic [TW_HALF-1:0] im;
   } tw_word_t;

   typedef struct packed {
      logic [TW_IDX_W-1:0] k;
      logic [TW_IDX_W-1:0] n;
      logic                last;
   } tw_tag_t;

   typedef struct packed {
      tw_word_t word;
      tw_tag_t  tag;
   } tw_entry_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } fetch_state_t;

   // Two's complement negate; the most negative value clamps to the most positive.
   function automatic logic [TW_HALF-1:0] neg_sat(input logic [TW_HALF-1:0] x);
      if (x == {1'b1, {(TW_HALF-1){1'b0}}})
         return {1'b0, {(TW_HALF-1){1'b1}}};
      return -x;
   endfunction

   function automatic logic len_is_legal(input logic [TW_IDX_W-1:0] len);
      return (len > TW_IDX_W'(1)) && ((len & (len - TW_IDX_W'(1))) == '0);
   endfunction

endpackage

// File: rtl/twiddle_skid_fifo.sv
// Small synchronous FIFO carrying tagged twiddle words, valid/ready read side,
// with an occupancy count used by the fetcher's credit check.
module twiddle_skid_fifo
   import twiddle_pkg::*;
#(
   parameter int DEPTH = 4,
   localparam int OCC_W = $clog2(DEPTH + 1),
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr_en_i,
   input  tw_entry_t        wr_data_i,
   output logic             rd_valid_o,
   input  logic             rd_ready_i,
   output tw_entry_t        rd_data_o,
   output logic [OCC_W-1:0] occ_o
);

   tw_entry_t        mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_q;
   logic [OCC_W-1:0] occ_q;
   logic [OCC_W-1:0] occ_d;
   logic             pop;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign rd_valid_o = (occ_q != '0);
   assign rd_data_o  = mem_q[rd_ptr_q];
   assign occ_o      = occ_q;
   assign pop        = rd_valid_o && rd_ready_i;

   always_comb begin
      occ_d = occ_q;
      case ({wr_en_i, pop})
         2'b10:   occ_d = occ_q + OCC_W'(1);
         2'b01:   occ_d = occ_q - OCC_W'(1);
         default: occ_d = occ_q;
      endcase
   end

   // Storage is cleared on reset so the read port presents zero when empty.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         occ_q    <= '0;
      end else begin
         if (wr_en_i) begin
            mem_q[wr_ptr_q] <= wr_data_i;
            wr_ptr_q        <= ptr_inc(wr_ptr_q);
         end
         if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
         occ_q <= occ_d;
      end
   end

endmodule

// File: rtl/twiddle_fetch.sv
// Sweeps (k, n) over an N-point DFT grid, drives the twiddle ROM indices and
// streams tagged words out. Optional conjugation: TWIDDLE_FETCH_CONJ_EN.
//
// state | meaning
// IDLE  | waiting for start; legal start issues (0,0) on the same edge
// RUN   | issuing one index per cycle while credit allows
// DRAIN | all indices issued; waiting for pipe and FIFO to empty
module twiddle_fetch
   import twiddle_pkg::*;
#(
   parameter int WIDTH      = 32,
   parameter int IDX_W      = 12,
   parameter int FIFO_DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [IDX_W-1:0] n_len,
`ifdef TWIDDLE_FETCH_CONJ_EN
   input  logic             inv,
`endif
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [IDX_W-1:0] rom_N,
   output logic [IDX_W-1:0] rom_k,
   output logic [IDX_W-1:0] rom_n,
   input  logic [WIDTH-1:0] rom_data,
   output logic [WIDTH-1:0] tw_data,
   output logic [IDX_W-1:0] tw_k,
   output logic [IDX_W-1:0] tw_n,
   output logic             tw_last,
   output logic             tw_valid,
   input  logic             tw_ready
);

   localparam int OCC_W = $clog2(FIFO_DEPTH + 1);
   localparam int CRD_W = OCC_W + 1;

   fetch_state_t     state_q;
   logic [IDX_W-1:0] len_q;
   logic [IDX_W-1:0] nk_q;
   logic [IDX_W-1:0] nn_q;
   logic [IDX_W-1:0] rom_k_q;
   logic [IDX_W-1:0] rom_n_q;
   logic             s1_v_q;
   tw_tag_t          s1_tag_q;
   logic             s2_v_q;
   tw_tag_t          s2_tag_q;
   logic [1:0]       inflight_q;
   logic             done_q;
   logic             err_q;
`ifdef TWIDDLE_FETCH_CONJ_EN
   logic             inv_q;
`endif

   logic [OCC_W-1:0] fifo_occ;
   logic [CRD_W-1:0] credit_used;
   logic [IDX_W-1:0] last_idx;
   logic             pop;
   logic             can_issue;
   logic             start_ok;
   logic             issue;
   logic [IDX_W-1:0] iss_k;
   logic [IDX_W-1:0] iss_n;
   logic             iss_last;
   logic             fifo_wr;
   tw_entry_t        wr_entry;
   tw_entry_t        rd_entry;
   tw_word_t         out_word;

   assign last_idx = len_q - IDX_W'(1);
   assign pop      = tw_valid && tw_ready;
   // A word leaving this cycle frees its slot in time for the word issued now.
   assign credit_used = CRD_W'(fifo_occ) + CRD_W'(inflight_q) - CRD_W'(pop);
   assign can_issue   = credit_used < CRD_W'(FIFO_DEPTH);
   assign start_ok    = start && len_is_legal(n_len);
   assign issue       = ((state_q == RUN) && can_issue) || ((state_q == IDLE) && start_ok);
   assign iss_k       = (state_q == RUN) ? nk_q : '0;
   assign iss_n       = (state_q == RUN) ? nn_q : '0;
   assign iss_last    = (state_q == RUN) && (nk_q == last_idx) && (nn_q == last_idx);
   assign fifo_wr     = s2_v_q;
   assign wr_entry    = {rom_data, s2_tag_q};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         len_q      <= '0;
         nk_q       <= '0;
         nn_q       <= '0;
         rom_k_q    <= '0;
         rom_n_q    <= '0;
         s1_v_q     <= 1'b0;
         s1_tag_q   <= '0;
         s2_v_q     <= 1'b0;
         s2_tag_q   <= '0;
         inflight_q <= '0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
`ifdef TWIDDLE_FETCH_CONJ_EN
         inv_q      <= 1'b0;
`endif
      end else begin
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         s1_v_q     <= issue;
         s2_v_q     <= s1_v_q;
         s2_tag_q   <= s1_tag_q;
         inflight_q <= inflight_q + 2'(issue) - 2'(fifo_wr);
         if (issue) begin
            rom_k_q  <= iss_k;
            rom_n_q  <= iss_n;
            s1_tag_q <= {iss_k, iss_n, iss_last};
         end
         case (state_q)
            IDLE: begin
               if (start_ok) begin
                  len_q   <= n_len;
                  nk_q    <= '0;
                  nn_q    <= IDX_W'(1);
                  state_q <= RUN;
`ifdef TWIDDLE_FETCH_CONJ_EN
                  inv_q   <= inv;
`endif
               end else if (start) begin
                  err_q <= 1'b1;
               end
            end
            RUN: begin
               if (can_issue) begin
                  if (iss_last) begin
                     state_q <= DRAIN;
                  end else if (nn_q == last_idx) begin
                     nn_q <= '0;
                     nk_q <= nk_q + IDX_W'(1);
                  end else begin
                     nn_q <= nn_q + IDX_W'(1);
                  end
               end
            end
            DRAIN: begin
               if ((inflight_q == '0) && (fifo_occ == '0)) begin
                  done_q  <= 1'b1;
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   twiddle_skid_fifo #(
      .DEPTH(FIFO_DEPTH)
   ) u_fifo (
      .clk        (clk),
      .rst_n      (rst_n),
      .wr_en_i    (fifo_wr),
      .wr_data_i  (wr_entry),
      .rd_valid_o (tw_valid),
      .rd_ready_i (tw_ready),
      .rd_data_o  (rd_entry),
      .occ_o      (fifo_occ)
   );

   always_comb begin
      out_word = rd_entry.word;
`ifdef TWIDDLE_FETCH_CONJ_EN
      if (inv_q) out_word.im = neg_sat(rd_entry.word.im);
`endif
   end

   assign busy    = (state_q != IDLE);
   assign done    = done_q;
   assign err     = err_q;
   assign rom_N   = len_q;
   assign rom_k   = rom_k_q;
   assign rom_n   = rom_n_q;
   assign tw_data = out_word;
   assign tw_k    = rd_entry.tag.k;
   assign tw_n    = rd_entry.tag.n;
   assign tw_last = rd_entry.tag.last;

endmodule

// File: tb/tb_twiddle_fetch.sv
// Directed bench for twiddle_fetch with a registered behavioural ROM.
module tb_twiddle_fetch;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [11:0] n_len = '0;
   logic        busy, done, err;
   logic [11:0] rom_N, rom_k, rom_n;
   logic [31:0] rom_data = '0;
   logic [31:0] tw_data;
   logic [11:0] tw_k, tw_n;
   logic        tw_last, tw_valid;
   logic        tw_ready = 1'b0;
`ifdef TWIDDLE_FETCH_CONJ_EN
   logic        inv = 1'b0;
   logic        ovr_en = 1'b0;
   logic [31:0] ovr_word = '0;
`endif

   int total = 0;
   int passed = 0;

   always #5 clk = ~clk;

   twiddle_fetch dut (
      .clk(clk), .rst_n(rst_n), .start(start), .n_len(n_len),
`ifdef TWIDDLE_FETCH_CONJ_EN
      .inv(inv),
`endif
      .busy(busy), .done(done), .err(err),
      .rom_N(rom_N), .rom_k(rom_k), .rom_n(rom_n), .rom_data(rom_data),
      .tw_data(tw_data), .tw_k(tw_k), .tw_n(tw_n), .tw_last(tw_last),
      .tw_valid(tw_valid), .tw_ready(tw_ready)
   );

   function automatic int exp_addr(input int nn, input int k, input int n);
      return ((4096 / nn) * k * n) % 4096;
   endfunction

   function automatic logic [31:0] rom_word(input int addr);
      logic [11:0] a;
      a = addr[11:0];
      return {4'hA, a, 4'h5, a ^ 12'hC3C};
   endfunction

   // ROM: one-cycle registered read
   always @(posedge clk) begin
`ifdef TWIDDLE_FETCH_CONJ_EN
      if (ovr_en) rom_data <= ovr_word;
      else
`endif
      rom_data <= (rom_N == 0) ? rom_word(0)
                  : rom_word(exp_addr(int'(rom_N), int'(rom_k), int'(rom_n)));
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
   endtask

   // mode 0: ready=1, 1: random ready + start while busy, 2: 20-cycle stall at word 20
   task automatic sweep(input int nlen, input int mode, input int abort_at);
      int words, cyc, done_cyc, last_hs, err_cnt, lat, stall_cnt, max_occ;
      logic stable;
      logic [55:0] hold;
      logic [23:0] rom_hold;
      logic [56:0] exp_w;
      int k, n;
      words = 0; cyc = 0; done_cyc = -1; last_hs = -1; err_cnt = 0; lat = -1;
      stall_cnt = 0; max_occ = 0; stable = 1'b1; hold = '0; rom_hold = '0;
      @(negedge clk);
      n_len = 12'(nlen);
      start = 1'b1;
      tw_ready = 1'b0;
      while (done_cyc < 0 && cyc < 3000) begin
         @(negedge clk);
         start = 1'b0;
         cyc++;
         if (abort_at > 0 && words == abort_at) begin
            rst_n = 1'b0;
            #1;
            chk("reset_ctrl", {busy, done, err, tw_valid, tw_last, rom_N, rom_k, rom_n}, '0);
            chk("reset_data", {tw_data, tw_k, tw_n}, '0);
            repeat (3) begin
               @(negedge clk);
               if (done || busy) stable = 1'b0;
            end
            rst_n = 1'b1;
            tw_ready = 1'b0;
            repeat (3) begin
               @(negedge clk);
               if (done || busy) stable = 1'b0;
            end
            chk("no_done_after_abort", stable, 1'b1);
            return;
         end
         if (done) done_cyc = cyc;
         if (err) err_cnt++;
         if (int'(dut.fifo_occ) > max_occ) max_occ = int'(dut.fifo_occ);
         if (tw_valid && lat < 0) lat = cyc - 1;
         case (mode)
            1: tw_ready = 1'($urandom_range(0, 1));
            2: tw_ready = !(words == 20 && stall_cnt < 20);
            default: tw_ready = 1'b1;
         endcase
         if (mode == 1 && cyc == 10) begin
            start = 1'b1;
            n_len = 12'd4;
         end
         if (mode == 2 && !tw_ready) begin
            stall_cnt++;
            if (stall_cnt == 1) hold = {tw_data, tw_k, tw_n};
            else if ({tw_data, tw_k, tw_n} !== hold) stable = 1'b0;
            if (stall_cnt == 12) rom_hold = {rom_k, rom_n};
            if (stall_cnt == 20) begin
               chk("stall_rom_idx_held", {rom_k, rom_n}, rom_hold);
               chk("stall_fifo_full", dut.fifo_occ, 4);
               chk("stall_valid", tw_valid, 1'b1);
            end
         end
         if (tw_valid && tw_ready && done_cyc < 0) begin
            k = words / nlen;
            n = words % nlen;
            exp_w = {12'(k), 12'(n), (words == nlen * nlen - 1), rom_word(exp_addr(nlen, k, n))};
            chk($sformatf("word%0d", words), {tw_k, tw_n, tw_last, tw_data}, exp_w);
            if (tw_last) last_hs = cyc;
            words++;
         end
      end
      chk("word_count", words, nlen * nlen);
      chk("done_seen", (done_cyc > 0), 1'b1);
      chk("done_delay", done_cyc - last_hs, 2);
      chk("busy_after_done", busy, 1'b0);
      chk("no_err", err_cnt, 0);
      chk("max_occ_le_depth", (max_occ <= 4), 1'b1);
      chk("rom_N_latched", rom_N, nlen);
      if (mode == 0) chk("first_valid_latency", lat, 2);
      if (mode == 2) chk("stall_data_stable", stable, 1'b1);
      @(negedge clk);
      chk("done_one_cycle", done, 1'b0);
      tw_ready = 1'b0;
   endtask

   task automatic err_case(input logic [11:0] len);
      logic [35:0] prev;
      prev = {rom_N, rom_k, rom_n};
      @(negedge clk);
      n_len = len;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk($sformatf("err_pulse_%0d", len), {err, busy}, 2'b10);
      chk($sformatf("err_rom_idx_%0d", len), {rom_N, rom_k, rom_n}, prev);
      @(negedge clk);
      chk($sformatf("err_clear_%0d", len), {err, busy}, 2'b00);
   endtask

`ifdef TWIDDLE_FETCH_CONJ_EN
   task automatic conj_case(input logic [31:0] w, input logic [31:0] exp);
      int cyc;
      cyc = 0;
      ovr_en = 1'b1;
      ovr_word = w;
      inv = 1'b1;
      @(negedge clk);
      n_len = 12'd2;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      while (!tw_valid && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      chk("conj_word", tw_data, exp);
      tw_ready = 1'b1;
      cyc = 0;
      while (!done && cyc < 40) begin
         @(negedge clk);
         cyc++;
      end
      chk("conj_done", done, 1'b1);
      tw_ready = 1'b0;
      inv = 1'b0;
      ovr_en = 1'b0;
   endtask
`endif

   initial begin
      repeat (3) @(negedge clk);
      chk("por_ctrl", {busy, done, err, tw_valid, tw_last, rom_N, rom_k, rom_n}, '0);
      chk("por_data", {tw_data, tw_k, tw_n}, '0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      sweep(2, 0, 0);
      sweep(8, 1, 0);
      sweep(16, 2, 0);
      err_case(12'd0);
      err_case(12'd3);
      err_case(12'd12);
      sweep(8, 0, 30);
      sweep(4, 0, 0);
`ifdef TWIDDLE_FETCH_CONJ_EN
      conj_case(32'h5A82A57E, 32'h5A825A82);
      conj_case(32'h12348000, 32'h12347FFF);
`endif

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
